// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Program sequencer for the 2-bit processor core. A host loads a small program
// of 2-bit instructions, then requests a run. Each instruction is stepped in
// two cycles: ISSUE drives the instruction and pulses the core clock enable,
// and WAIT samples the core state that results. A run ends after len steps,
// on an abort, or early when the core state matches halt_state (if enabled).
//
// Ports
//   clk          system clock, rising edge (shared with the core)
//   reset        asynchronous active-low reset (same net resets the core)
//   wr_en        program write strobe, honoured only in IDLE
//   wr_addr      program slot to write
//   wr_data      instruction {i1,i0} to store
//   len          instructions to run; values above DEPTH clamp to DEPTH
//   start        run request, honoured only in IDLE
//   abort        stop the current run
//   halt_en      enable early stop on a core state match
//   halt_state   core state {c1,c0} that triggers the early stop
//   core_c       core state {c1,c0}
//   core_i       instruction {i1,i0} to the core (00 outside ISSUE)
//   core_clk_en  core clock enable, one-cycle pulses in ISSUE
//   busy         high in ISSUE and WAIT
//   done         one-cycle pulse at the end of a run
//   halted       set when a run ends on a halt match
//   steps        instructions completed in the current or last run
//   last_state   core_c captured after the most recent step
//   dbg_state    current FSM state (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
//
// Handshake: start is a level sampled on the rising edge only while the FSM is
// in IDLE; every accepted start produces exactly one done pulse unless reset
// intervenes. There is no backpressure: start and wr_en seen outside IDLE are
// dropped, so the host must wait for done (or busy low) before reusing them.
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  input  logic [PW:0]   len,
  input  logic          start,
  input  logic          abort,
  input  logic          halt_en,
  input  logic [1:0]    halt_state,
  input  logic [1:0]    core_c,
  output logic [1:0]    core_i,
  output logic          core_clk_en,
  output logic          busy,
  output logic          done,
  output logic          halted,
  output logic [PW:0]   steps,
  output logic [1:0]    last_state,
  output logic [1:0]    dbg_state
);

  localparam int          DEPTH   = 1 << PW;
  localparam logic [PW:0] DEPTH_L = (PW + 1)'(DEPTH);
  localparam logic [PW:0] ONE_S   = (PW + 1)'(1);
  localparam logic [PW-1:0] ONE_PC = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [PW-1:0] pc_q;
  logic [PW:0]   len_q;
  logic [PW:0]   steps_q;
  logic [1:0]    last_q;
  logic          halted_q;
  logic [1:0]    mem_q [DEPTH];

  logic [PW:0]   len_eff;
  logic [PW:0]   steps_d;
  logic          halt_hit;

  // len is one bit wider than the program address so DEPTH itself is
  // expressible; anything larger would run past the end of the program.
  assign len_eff  = (len > DEPTH_L) ? DEPTH_L : len;
  assign steps_d  = steps_q + ONE_S;
  assign halt_hit = halt_en && (core_c == halt_state);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      steps_q  <= '0;
      last_q   <= 2'b00;
      halted_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 2'b00;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
          end
          if (start) begin
            // A zero-length run reports done without touching the
            // results of the previous run.
            if (len_eff == '0) begin
              state_q <= S_DONE;
            end else begin
              pc_q     <= '0;
              steps_q  <= '0;
              halted_q <= 1'b0;
              len_q    <= len_eff;
              state_q  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // An aborted issue never pulsed the core, so no step is counted.
          state_q <= abort ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          last_q  <= core_c;
          steps_q <= steps_d;
          pc_q    <= pc_q + ONE_PC;
          // Halt is checked first so a match on the final step still
          // reports halted.
          if (halt_hit) begin
            halted_q <= 1'b1;
            state_q  <= S_DONE;
          end else if ((steps_d == len_q) || abort) begin
            state_q <= S_DONE;
          end else begin
            state_q <= S_ISSUE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode the registered state. core_clk_en is combinational with
  // abort so an abort in ISSUE suppresses that cycle's pulse, and it is
  // gated by reset so a mid-run reset removes the pulse immediately.
  assign core_i      = (state_q == S_ISSUE) ? mem_q[pc_q] : 2'b00;
  assign core_clk_en = (state_q == S_ISSUE) && !abort && reset;
  assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign done        = (state_q == S_DONE);
  assign halted      = halted_q;
  assign steps       = steps_q;
  assign last_state  = last_q;
  assign dbg_state   = state_q;

endmodule
